shapool_sweeper: RTL and testbench
==================================

# shapool_sweeper

Parametrised nonce-sweep controller for the next-generation SHA-256 mining pool. Drives a pool of POOL_SIZE iterative double-hash cores with per-core nonces, checks each pass's final-hash top word against a runtime leading-zero difficulty, and returns every winning nonce through a valid/ready result port. Supports stop-on-first-hit and continue-sweeping modes, and reports range exhaustion.

## Interface
- POOL_SIZE, 4: number of hash cores; must equal 2**POOL_SIZE_LOG2 (1..16).
- POOL_SIZE_LOG2, 2: log2 of POOL_SIZE (0..4).
- NONCE_LOW_WIDTH, 24: nonce bits below the device prefix; counter width CW = NONCE_LOW_WIDTH - POOL_SIZE_LOG2 (≥1).
- BASE_DIFFICULTY, 1: leading zero bits always required.
- STOP_ON_SUCCESS, 1: 1 = finish after first acknowledged result; 0 = keep sweeping.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  pulse; latches job, begins sweep (ignored while busy).
- halt  in  1  abort sweep.
- nonce_start_MSB  in  8  device prefix, nonce[31:24] (NONCE_LOW_WIDTH=24).
- difficulty  in  8  extra leading zeros; latched on start.
- core_hash_top  in  POOL_SIZE*64  final hash bits [255:192] per core; core k at [64k+63:64k].
- core_done  in  1  single-cycle pulse: all cores finished current pass.
- core_load  out  1  single-cycle pulse: cores load core_nonce and start.
- core_nonce  out  POOL_SIZE*32  nonce per core, core k at [32k+31:32k].
- busy  out  1  sweep in progress.
- result_valid  out  1  winning nonce available.
- result_ready  in  1  consumer accepts result.
- result_nonce  out  32  winning nonce.
- success  out  1  sticky: at least one hit this job.
- exhausted  out  1  sticky: full counter range swept.

## Operation
- Nonce of core k = {nonce_start_MSB, counter[CW-1:0], k[POOL_SIZE_LOG2-1:0]}; no index field when POOL_SIZE_LOG2=0. Prefix and difficulty latched on start.
- Required zeros req = min(BASE_DIFFICULTY + difficulty, 64), 9-bit sum before clamp. Core k hits iff top req bits of its 64-bit word are all zero; req=0 → always hit.
- States:
  - IDLE: busy=0. start → LOAD; counter=0; success, exhausted cleared.
  - LOAD: core_load=1 for exactly one cycle; core_nonce registered, stable until next LOAD → WAIT.
  - WAIT: core_done → capture hit mask → CHECK. core_done in other states ignored.
  - CHECK: mask zero → ADVANCE; nonzero → REPORT, success=1.
  - REPORT: result_valid=1, result_nonce = nonce of lowest-index set mask bit; nonce held stable while result_ready=0. On valid&ready: clear that bit; STOP_ON_SUCCESS=1 → DONE; else remaining mask nonzero → stay (next result next cycle); else → ADVANCE.
  - ADVANCE: counter all-ones → DONE, exhausted=1; else counter+1 → LOAD.
  - DONE: busy=0, success/exhausted held. start → LOAD as from IDLE.
- halt (any state except IDLE/DONE) → DONE next edge; result_valid drops, mask cleared, exhausted unchanged; halt wins over simultaneous core_done or result handshake.
- start while busy: ignored.

## Timing
- Reset (reset=0, async): state IDLE; busy, core_load, result_valid, success, exhausted = 0; core_nonce, result_nonce, counter, mask = 0.
- start sampled at edge t → core_load high in cycle t+1, busy high from t+1.
- core_done at edge t → CHECK at t+1 → result_valid or ADVANCE at t+2; next core_load at t+3 if no hit.
- Successive results within one pass: one per accepted handshake, back-to-back when result_ready held high.
- busy is high in LOAD/WAIT/CHECK/REPORT/ADVANCE only.

## Test plan
- Reset mid-REPORT (result_valid=1) → all outputs 0 immediately, no clock needed; subsequent start behaves as fresh job.
- POOL_SIZE=4, start with MSB=0x5A, difficulty=3 → core_load one cycle later, core_nonce = 5A000000/01/02/03; core_done with all tops 0xFFFF_FFFF_FFFF_FFFF → next load 5A000004..07, no result.
- STOP_ON_SUCCESS=0, req=4: core1 top 0x0FFF_..., core3 top 0x0000_..., core0 top 0x1000_... → results 5A000001 then 5A000003 (held 5 cycles with ready low), core0 not reported; sweep continues at 5A000004; success=1.
- difficulty=0xFF → req=64: only top==0 hits; top=0x0000_0000_0000_0001 → no hit.
- NONCE_LOW_WIDTH=4, POOL_SIZE_LOG2=2, no hits → exactly 4 core_load pulses (last nonces 0x0000000C..0F), then exhausted=1, busy=0.
- halt during WAIT with simultaneous core_done (hitting) → DONE, result_valid never asserts, success=0, exhausted=0; start then restarts at counter 0.

Source files
------------

// File: rtl/shapool_sweeper.sv
// shapool_sweeper
// Nonce-sweep controller for a pool of POOL_SIZE iterative double-hash cores.
// Each pass hands every core its own nonce {prefix, counter, core index},
// waits for the pool to finish, tests each core's final-hash top word against
// a leading-zero difficulty, and returns every winning nonce through a
// valid/ready result port. The sweep ends on halt, on range exhaustion or,
// when STOP_ON_SUCCESS is set, after the first accepted result.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   start             pulse: latch prefix/difficulty and begin a sweep (ignored while busy)
//   halt              abort the sweep in progress
//   nonce_start_MSB   device prefix placed above the NONCE_LOW_WIDTH low bits
//   difficulty        extra leading zeros on top of BASE_DIFFICULTY
//   core_hash_top     per-core hash bits [255:192], core k at [64k+63:64k]
//   core_done         pulse: all cores finished the current pass
//   core_load         pulse: cores load core_nonce and start
//   core_nonce        per-core nonce, core k at [32k+31:32k]
//   busy              sweep in progress
//   result_valid/result_ready/result_nonce   winning-nonce handshake
//   success           sticky: at least one hit this job
//   exhausted         sticky: the whole counter range was swept
module shapool_sweeper #(
   parameter int POOL_SIZE       = 4,
   parameter int POOL_SIZE_LOG2  = 2,
   parameter int NONCE_LOW_WIDTH = 24,
   parameter int BASE_DIFFICULTY = 1,
   parameter int STOP_ON_SUCCESS = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    halt,
   input  logic [7:0]              nonce_start_MSB,
   input  logic [7:0]              difficulty,
   input  logic [POOL_SIZE*64-1:0] core_hash_top,
   input  logic                    core_done,
   output logic                    core_load,
   output logic [POOL_SIZE*32-1:0] core_nonce,
   output logic                    busy,
   output logic                    result_valid,
   input  logic                    result_ready,
   output logic [31:0]             result_nonce,
   output logic                    success,
   output logic                    exhausted
);
   localparam int CW = NONCE_LOW_WIDTH - POOL_SIZE_LOG2;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_WAIT, S_CHECK, S_REPORT, S_ADVANCE, S_DONE
   } state_t;

   state_t                  state_q, state_next;
   logic [CW-1:0]           counter_q, counter_next;
   logic [POOL_SIZE-1:0]    mask_q, mask_next, hit_vec;
   logic [7:0]              prefix_q, prefix_next;
   logic [6:0]              req_q;
   logic [POOL_SIZE*32-1:0] core_nonce_q, nonce_vec_next;
   logic [31:0]             result_nonce_q;
   logic                    success_q, exhausted_q;
   logic                    latch_job, load_nonce, set_success, set_exhausted;

   // Required leading zeros, saturated at the 64-bit word width.
   function automatic logic [6:0] sat_req(input logic [7:0] diff);
      logic [8:0] sum;
      sum = 9'(BASE_DIFFICULTY) + {1'b0, diff};
      return (sum > 9'd64) ? 7'd64 : sum[6:0];
   endfunction

   function automatic logic [31:0] nonce_of(input logic [7:0] pfx,
                                            input logic [CW-1:0] cnt,
                                            input int k);
      return (32'(pfx) << NONCE_LOW_WIDTH) | (32'(cnt) << POOL_SIZE_LOG2) | 32'(k);
   endfunction

   function automatic int lowest_idx(input logic [POOL_SIZE-1:0] m);
      int idx;
      idx = 0;
      for (int i = POOL_SIZE - 1; i >= 0; i--)
         if (m[i]) idx = i;
      return idx;
   endfunction

   // A core hits when its top req bits are zero; req=0 shifts by 64 and always hits.
   always_comb begin
      hit_vec = '0;
      for (int k = 0; k < POOL_SIZE; k++)
         hit_vec[k] = ((core_hash_top[64*k +: 64] >> (7'd64 - req_q)) == 64'd0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_next;
   end

   always_comb begin
      state_next    = state_q;
      counter_next  = counter_q;
      mask_next     = mask_q;
      latch_job     = 1'b0;
      load_nonce    = 1'b0;
      set_success   = 1'b0;
      set_exhausted = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_next   = S_LOAD;
               counter_next = '0;
               mask_next    = '0;
               latch_job    = 1'b1;
               load_nonce   = 1'b1;
            end
         end
         S_LOAD: state_next = S_WAIT;
         S_WAIT: begin
            if (core_done) begin
               mask_next  = hit_vec;
               state_next = S_CHECK;
            end
         end
         S_CHECK: begin
            if (mask_q == '0) begin
               state_next = S_ADVANCE;
            end else begin
               state_next  = S_REPORT;
               set_success = 1'b1;
            end
         end
         S_REPORT: begin
            if (result_ready) begin
               // Drop the lowest set bit: that is the one just reported.
               mask_next = mask_q & (mask_q - 1'b1);
               if (STOP_ON_SUCCESS != 0) begin
                  state_next = S_DONE;
                  mask_next  = '0;
               end else if (mask_next == '0) begin
                  state_next = S_ADVANCE;
               end
            end
         end
         S_ADVANCE: begin
            if (&counter_q) begin
               state_next    = S_DONE;
               set_exhausted = 1'b1;
            end else begin
               state_next   = S_LOAD;
               counter_next = counter_q + 1'b1;
               load_nonce   = 1'b1;
            end
         end
         default: state_next = S_IDLE;
      endcase
      // Halt overrides everything decided above for an active sweep.
      if (halt && (state_q != S_IDLE) && (state_q != S_DONE)) begin
         state_next    = S_DONE;
         counter_next  = counter_q;
         mask_next     = '0;
         load_nonce    = 1'b0;
         set_success   = 1'b0;
         set_exhausted = 1'b0;
      end
   end

   // Nonces for the pass being entered; prefix comes straight from the port on start.
   always_comb begin
      prefix_next    = latch_job ? nonce_start_MSB : prefix_q;
      nonce_vec_next = '0;
      for (int k = 0; k < POOL_SIZE; k++)
         nonce_vec_next[32*k +: 32] = nonce_of(prefix_next, counter_next, k);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         counter_q      <= '0;
         mask_q         <= '0;
         prefix_q       <= '0;
         req_q          <= '0;
         core_nonce_q   <= '0;
         result_nonce_q <= '0;
         success_q      <= 1'b0;
         exhausted_q    <= 1'b0;
      end else begin
         counter_q <= counter_next;
         mask_q    <= mask_next;
         if (latch_job) begin
            prefix_q    <= nonce_start_MSB;
            req_q       <= sat_req(difficulty);
            success_q   <= 1'b0;
            exhausted_q <= 1'b0;
         end
         if (set_success)   success_q   <= 1'b1;
         if (set_exhausted) exhausted_q <= 1'b1;
         if (load_nonce)    core_nonce_q <= nonce_vec_next;
         // Core nonces are stable from LOAD to REPORT, so the winner is picked from them.
         if (state_next == S_REPORT)
            result_nonce_q <= core_nonce_q[32*lowest_idx(mask_next) +: 32];
      end
   end

   assign core_load    = (state_q == S_LOAD);
   assign result_valid = (state_q == S_REPORT);
   assign busy         = (state_q == S_LOAD) || (state_q == S_WAIT) || (state_q == S_CHECK) ||
                         (state_q == S_REPORT) || (state_q == S_ADVANCE);
   assign core_nonce   = core_nonce_q;
   assign result_nonce = result_nonce_q;
   assign success      = success_q;
   assign exhausted    = exhausted_q;

endmodule

// File: tb/tb_shapool_sweeper.sv
// Bench for shapool_sweeper: a continue-sweeping instance (4 cores, 4 low
// nonce bits, so 4 passes per job) driven with random hash words and checked
// by a scoreboard, plus a stop-on-success instance exercised directly.
module tb_shapool_sweeper;
   localparam int NPASS = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset, start, halt, core_done, result_ready;
   logic [7:0]   nonce_start_MSB, difficulty;
   logic [255:0] core_hash_top;
   logic         core_load, busy, result_valid, success, exhausted;
   logic [127:0] core_nonce;
   logic [31:0]  result_nonce;

   logic         s_start, s_halt, s_core_done, s_result_ready;
   logic [7:0]   s_nonce_start_MSB, s_difficulty;
   logic [255:0] s_core_hash_top;
   logic         s_core_load, s_busy, s_result_valid, s_success, s_exhausted;
   logic [127:0] s_core_nonce;
   logic [31:0]  s_result_nonce;

   shapool_sweeper #(.POOL_SIZE(4), .POOL_SIZE_LOG2(2), .NONCE_LOW_WIDTH(4),
                     .BASE_DIFFICULTY(1), .STOP_ON_SUCCESS(0)) dut (
      .clk(clk), .reset(reset), .start(start), .halt(halt),
      .nonce_start_MSB(nonce_start_MSB), .difficulty(difficulty),
      .core_hash_top(core_hash_top), .core_done(core_done),
      .core_load(core_load), .core_nonce(core_nonce), .busy(busy),
      .result_valid(result_valid), .result_ready(result_ready),
      .result_nonce(result_nonce), .success(success), .exhausted(exhausted));

   shapool_sweeper #(.POOL_SIZE(4), .POOL_SIZE_LOG2(2), .NONCE_LOW_WIDTH(4),
                     .BASE_DIFFICULTY(1), .STOP_ON_SUCCESS(1)) dut_s (
      .clk(clk), .reset(reset), .start(s_start), .halt(s_halt),
      .nonce_start_MSB(s_nonce_start_MSB), .difficulty(s_difficulty),
      .core_hash_top(s_core_hash_top), .core_done(s_core_done),
      .core_load(s_core_load), .core_nonce(s_core_nonce), .busy(s_busy),
      .result_valid(s_result_valid), .result_ready(s_result_ready),
      .result_nonce(s_result_nonce), .success(s_success), .exhausted(s_exhausted));

   int checks = 0;
   int errors = 0;
   logic [127:0] exp_load_q[$];
   logic [31:0]  exp_res_q[$];
   int  load_count;
   int  cur_pfx, cur_req;
   bit  exp_success;
   bit  rdy_hold = 1'b0;
   bit  rdy_random = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=event", name);
   endtask

   // Reference model: nonce = prefix*2^4 + pass*4 + core; hit = leading zeros >= req.
   function automatic int clz64(input logic [63:0] v);
      for (int i = 63; i >= 0; i--)
         if (v[i]) return 63 - i;
      return 64;
   endfunction

   function automatic int req_of(input int diff);
      return (1 + diff > 64) ? 64 : 1 + diff;
   endfunction

   function automatic logic [31:0] model_nonce(input int pfx, input int pass, input int k);
      return 32'(pfx * 16 + pass * 4 + k);
   endfunction

   function automatic logic [127:0] load_vec(input int pfx, input int pass);
      logic [127:0] v;
      for (int k = 0; k < 4; k++) v[32*k +: 32] = model_nonce(pfx, pass, k);
      return v;
   endfunction

   function automatic logic [63:0] rand_top();
      int lz;
      logic [63:0] r;
      lz = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 64)) : int'($urandom_range(0, 8));
      r  = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
      return (lz >= 64) ? 64'd0 : (r >> lz);
   endfunction

   function automatic logic [255:0] rand_tops();
      return {rand_top(), rand_top(), rand_top(), rand_top()};
   endfunction

   // Monitor: pops the scoreboard whenever the DUT presents a load or a result.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) continue;
         if (core_load) begin
            load_count++;
            if (exp_load_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_load actual=%0h required=none", core_nonce);
            end else check("core_nonce", core_nonce, exp_load_q.pop_front());
         end
         if (result_valid) begin
            if (exp_res_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_result actual=%0h required=none", result_nonce);
            end else if (result_ready) begin
               check("result_nonce", result_nonce, exp_res_q.pop_front());
            end else begin
               check("result_held", result_nonce, exp_res_q[0]);
            end
         end
      end
   end

   initial begin
      result_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         result_ready = rdy_hold ? 1'b0 : (rdy_random ? 1'($urandom_range(0, 1)) : 1'b1);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_start(input int pfx, input int diff);
      cur_pfx = pfx; cur_req = req_of(diff); exp_success = 1'b0; load_count = 0;
      exp_load_q.push_back(load_vec(pfx, 0));
      nonce_start_MSB = 8'(pfx); difficulty = 8'(diff); start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_pass(input int pass, input logic [255:0] tops, input bit halt_now,
                          input bit stray_start);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (core_load) begin ok = 1'b1; break; end
      end
      if (!ok) begin timeout_fail("wait_load"); return; end
      tick();
      if (stray_start) begin
         nonce_start_MSB = ~nonce_start_MSB; start = 1'b1;
         tick();
         start = 1'b0;
      end
      repeat ($urandom_range(0, 3)) tick();
      core_hash_top = tops; core_done = 1'b1; halt = halt_now;
      if (!halt_now) begin
         for (int k = 0; k < 4; k++)
            if (clz64(tops[64*k +: 64]) >= cur_req) begin
               exp_res_q.push_back(model_nonce(cur_pfx, pass, k));
               exp_success = 1'b1;
            end
         if (pass < NPASS - 1) exp_load_q.push_back(load_vec(cur_pfx, pass + 1));
      end
      tick();
      core_done = 1'b0; halt = 1'b0;
   endtask

   task automatic finish_job(input string tag, input bit exp_exh, input int exp_loads);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy) begin ok = 1'b1; break; end
      end
      if (!ok) timeout_fail({tag, "_busy_drop"});
      check({tag, "_exhausted"}, exhausted, exp_exh);
      check({tag, "_success"}, success, exp_success);
      check({tag, "_valid_idle"}, result_valid, 1'b0);
      check({tag, "_loads"}, load_count, exp_loads);
      check({tag, "_pending"}, exp_res_q.size() + exp_load_q.size(), 0);
      tick();
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (result_valid) begin ok = 1'b1; break; end
      end
      if (!ok) timeout_fail("wait_valid");
   endtask

   initial begin
      int diffs[9] = '{0, 1, 2, 4, 7, 62, 63, 255, 3};
      bit ok;
      int cnt;
      reset = 1'b0; start = 1'b0; halt = 1'b0; core_done = 1'b0;
      nonce_start_MSB = '0; difficulty = '0; core_hash_top = '0;
      s_start = 1'b0; s_halt = 1'b0; s_core_done = 1'b0; s_result_ready = 1'b1;
      s_nonce_start_MSB = '0; s_difficulty = '0; s_core_hash_top = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_load", core_load, 1'b0);
      check("rst_nonce", core_nonce, 128'd0);
      check("rst_flags", {result_valid, success, exhausted}, 3'b000);
      reset = 1'b1;
      tick();

      // Prefix 0x5A, difficulty 3 (req 4); pass 1 carries a directed hit pattern.
      do_start(8'h5A, 3);
      do_pass(0, {4{64'hFFFF_FFFF_FFFF_FFFF}}, 1'b0, 1'b0);
      rdy_hold = 1'b1;
      do_pass(1, {64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'h0FFF_FFFF_FFFF_FFFF, 64'h1000_0000_0000_0000}, 1'b0, 1'b0);
      wait_valid(ok);
      repeat (5) @(negedge clk);
      check("success_in_report", success, 1'b1);
      @(posedge clk); #1;
      rdy_hold = 1'b0;
      do_pass(2, rand_tops(), 1'b0, 1'b1);
      do_pass(3, rand_tops(), 1'b0, 1'b0);
      finish_job("directed", 1'b1, 4);

      // Maximum difficulty: only an all-zero word hits.
      do_start(8'h33, 255);
      do_pass(0, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_8000_0000,
                  64'h0000_0000_0000_0000, 64'h0000_0000_0000_0001}, 1'b0, 1'b0);
      for (int p = 1; p < NPASS; p++) do_pass(p, rand_tops(), 1'b0, 1'b0);
      finish_job("diff255", 1'b1, 4);

      // Random jobs with random consumer back-pressure.
      rdy_random = 1'b1;
      for (int j = 0; j < 9; j++) begin
         do_start(int'($urandom_range(0, 255)), diffs[j]);
         for (int p = 0; p < NPASS; p++)
            do_pass(p, rand_tops(), 1'b0, ($urandom_range(0, 3) == 0));
         finish_job("random", 1'b1, 4);
      end
      rdy_random = 1'b0;

      // Halt in WAIT together with a hitting core_done, then a fresh restart.
      do_start(8'h77, 0);
      do_pass(0, 256'd0, 1'b1, 1'b0);
      finish_job("halt", 1'b0, 1);
      do_start(8'h78, 1);
      for (int p = 0; p < NPASS; p++) do_pass(p, rand_tops(), 1'b0, 1'b0);
      finish_job("after_halt", 1'b1, 4);

      // Asynchronous reset while a result is pending.
      rdy_hold = 1'b1;
      do_start(8'h12, 0);
      do_pass(0, 256'd0, 1'b0, 1'b0);
      wait_valid(ok);
      #2 reset = 1'b0;
      #1;
      check("arst_flags", {busy, core_load, result_valid, success, exhausted}, 5'b00000);
      check("arst_nonces", {core_nonce, result_nonce}, 160'd0);
      exp_res_q.delete();
      exp_load_q.delete();
      rdy_hold = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      tick();
      do_start(8'h13, 2);
      for (int p = 0; p < NPASS; p++) do_pass(p, rand_tops(), 1'b0, 1'b0);
      finish_job("after_reset", 1'b1, 4);

      // Stop-on-success instance: the first accepted result ends the job.
      s_nonce_start_MSB = 8'hA5; s_difficulty = 8'd0; s_start = 1'b1;
      tick();
      s_start = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (s_core_load) begin ok = 1'b1; break; end
      end
      if (!ok) timeout_fail("s_wait_load");
      check("s_core_nonce", s_core_nonce, load_vec(8'hA5, 0));
      tick();
      s_core_hash_top = {64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
      s_core_done = 1'b1;
      tick();
      s_core_done = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (s_result_valid) begin ok = 1'b1; break; end
      end
      if (!ok) timeout_fail("s_wait_valid");
      check("s_result_nonce", s_result_nonce, 32'h0000_0A51);
      @(negedge clk);
      check("s_done_flags", {s_busy, s_result_valid, s_success, s_exhausted}, 4'b0010);
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (s_core_load || s_result_valid) cnt++;
      end
      check("s_no_more_activity", cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
